// File: rtl/a0_uart_tx.sv
// Observer for the core's a0 register: every accepted change of a0 is queued in a small
// FIFO and sent least-significant byte first over a UART 8N1 line. The core is never stalled.
module a0_uart_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              a0,
  input  logic                               en,
  input  logic                               clr_overflow,
  output logic                               tx,
  output logic                               busy,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic [1:0]                         dbg_state
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int BW     = $clog2(CLKS_PER_BIT);
  localparam int YW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [YW-1:0] BYTE_LAST = YW'(NBYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [DATA_WIDTH-1:0] a0_q, a0_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [1:0]            state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [YW-1:0]         byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;

  logic change, push, pop, push_ok, bit_end;

  // FIFO handshake: push is a one-cycle strobe with no backpressure (the core is never
  // stalled); it is accepted when there is room or a pop frees a slot in the same cycle,
  // otherwise the word is dropped and overflow is flagged. pop is the serialiser taking
  // the head word whenever it is IDLE and the FIFO is non-empty.
  always_comb begin
    a0_d    = a0;
    change  = (a0 != a0_q);
    push    = change && en;
    pop     = (state_q == S_IDLE) && (count_q != '0);
    push_ok = push && ((count_q < DEPTH_C) || pop);

    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    overflow_d = overflow_q;
    if (clr_overflow)     overflow_d = 1'b0;
    if (push && !push_ok) overflow_d = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    bit_end    = (baud_q == BAUD_LAST);
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d    = mem_q[rd_ptr_q];
          byte_idx_d = '0;
          baud_d     = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          // Shifting after every data bit leaves the next byte in the low bits.
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        if (bit_end) begin
          baud_d = '0;
          if (byte_idx_q != BYTE_LAST) begin
            byte_idx_d = byte_idx_q + YW'(1);
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= a0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a0_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      a0_q       <= a0_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_a0_uart_tx.sv
// Bench for a0_uart_tx: directed a0 changes push expected words into a queue; a UART
// receiver process decodes tx and compares every received word against the queue head.
module tb_a0_uart_tx;
  localparam int DW  = 32;
  localparam int CPB = 4;
  localparam int FD  = 8;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst;
  logic [DW-1:0] a0;
  logic          en;
  logic          clr_overflow;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [3:0]    fifo_count;
  logic [1:0]    dbg_state;

  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int words_seen = 0;

  a0_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .a0(a0), .en(en), .clr_overflow(clr_overflow),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_n(input int n, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst) ok = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || fifo_count != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] v);
    @(negedge clk);
    a0 = v;
    exp_q.push_back(v);
  endtask

  // scoreboard monitor: UART receiver sampling near mid-bit
  initial begin : monitor
    logic [DW-1:0] word;
    logic [7:0]    b;
    int            nbytes;
    bit            ok;
    word = '0;
    nbytes = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nbytes = 0;
      end else if (tx == 1'b0) begin
        wait_n(2, ok);
        if (ok) check("start_bit", 32'(tx), 32'd0);
        for (int k = 0; k < 8; k++) begin
          if (ok) begin
            wait_n(CPB, ok);
            b[k] = tx;
          end
        end
        if (ok) begin
          wait_n(CPB, ok);
          if (ok) check("stop_bit", 32'(tx), 32'd1);
        end
        if (!ok) begin
          nbytes = 0;
        end else begin
          word = {b, word[DW-1:8]};
          nbytes++;
          if (nbytes == DW / 8) begin
            nbytes = 0;
            words_seen++;
            if (exp_q.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_word: got %h expected none", word);
            end else begin
              check("word", word, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    int seen0;
    rst = 1'b1;
    a0 = '0;
    en = 1'b1;
    clr_overflow = 1'b0;

    // reset with no clock running
    #5 rst = 1'b0;
    #15;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) n++;
    end
    check("idle_tx_low_samples", 32'(n), 32'd0);

    // single word: latency and busy duration
    send(32'h1234_5678);
    @(posedge clk); #1;
    check("edge1_tx", 32'(tx), 32'd1);
    check("edge1_fifo_count", 32'(fifo_count), 32'd1);
    @(posedge clk); #1;
    check("edge2_tx_start", 32'(tx), 32'd0);
    check("edge2_busy", 32'(busy), 32'd1);
    check("edge2_fifo_count", 32'(fifo_count), 32'd0);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("busy_cycles", 32'(n), 32'd160);
    check("after_word_fifo_count", 32'(fifo_count), 32'd0);
    repeat (3) @(negedge clk);

    // stable a0: one frame only
    seen0 = words_seen;
    send(32'h0000_00A5);
    @(posedge clk); @(posedge clk);
    wait_idle(1000);
    repeat (1000) @(negedge clk);
    check("stable_word_count", 32'(words_seen - seen0), 32'd1);

    // overflow: ten consecutive changes
    seen0 = words_seen;
    for (int v = 1; v <= 10; v++) begin
      @(negedge clk);
      a0 = DW'(v);
      if (v <= 9) exp_q.push_back(DW'(v));
      if (v == 10) begin
        check("full_fifo_count", 32'(fifo_count), 32'd8);
        check("full_no_overflow_yet", 32'(overflow), 32'd0);
      end
    end
    @(posedge clk); #1;
    check("ovf_fifo_count", 32'(fifo_count), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_busy", 32'(busy), 32'd1);
    wait_idle(3000);
    check("ovf_word_count", 32'(words_seen - seen0), 32'd9);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // enable gating
    seen0 = words_seen;
    @(negedge clk);
    en = 1'b0;
    a0 = 32'h55;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (20) @(negedge clk);
    check("gate_fifo_count", 32'(fifo_count), 32'd0);
    check("gate_busy", 32'(busy), 32'd0);
    check("gate_tx", 32'(tx), 32'd1);
    send(32'h66);
    @(posedge clk); @(posedge clk);
    wait_idle(1000);
    check("gate_word_count", 32'(words_seen - seen0), 32'd1);

    // async reset mid-frame with two words queued
    seen0 = words_seen;
    @(negedge clk); a0 = 32'h1111_1111;
    @(negedge clk); a0 = 32'h2222_2222;
    @(negedge clk); a0 = 32'h3333_3333;
    @(negedge clk);
    check("pre_reset_fifo_count", 32'(fifo_count), 32'd2);
    repeat (50) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_fifo_count", 32'(fifo_count), 32'd0);
    a0 = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check("post_rst_no_words", 32'(words_seen - seen0), 32'd0);
    check("post_rst_fifo_count", 32'(fifo_count), 32'd0);
    send(32'h0BAD_F00D);
    @(posedge clk); @(posedge clk);
    wait_idle(1000);
    check("post_rst_word_count", 32'(words_seen - seen0), 32'd1);

    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/a0_uart_tx.md
Name: a0_uart_tx

Overview:
- Downstream consumer of the pipelined core's architectural a0 output.
- Detects every change of a0 and queues the new value in a small FIFO.
- Serialises each queued word over a UART 8N1 line, so program results can be observed off-chip without a logic probe.
- Sits beside the core in the board-level wrapper. It is purely an observer and never stalls the core.

Parameters:
- DATA_WIDTH, 32, width of a0. Must be a multiple of 8.
- CLKS_PER_BIT, 868, clock cycles per UART bit. Must be ≥ 2.
- FIFO_DEPTH, 8, number of queued words. Must be a power of 2 and ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- a0  input  DATA_WIDTH  a0 value from the core.
- en  input  1  capture enable. When 0, a0 changes are not queued.
- clr_overflow  input  1  synchronous clear of the overflow flag.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a word is being shifted out.
- overflow  output  1  sticky flag: a change was dropped because the FIFO was full.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of words currently queued.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - a0_q=0, FSM=IDLE, all counters 0.
  - Any frame in progress is abandoned immediately.
- Change detect:
  - a0_q <= a0 on every clock, regardless of en.
  - change = (a0 != a0_q).
  - push = change && en.
  - A nonzero a0 seen after reset therefore produces a push. A value changed while en=0 is never queued later.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - pop occurs when FSM is IDLE and fifo_count != 0.
  - A push is accepted when fifo_count < FIFO_DEPTH, or when a pop happens in the same cycle.
  - Simultaneous accepted push and pop leave fifo_count unchanged.
  - A rejected push sets overflow=1; the word is lost.
  - overflow clears on clr_overflow=1. If a set and a clear occur in the same cycle, set wins.
- Serialiser FSM: states IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1.
    - On pop, latch the head word into the shift register, set byte_idx=0, go to START.
  - START:
    - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA:
    - tx = current byte bit bit_idx, LSB first.
    - Each bit is held CLKS_PER_BIT cycles.
    - After bit 7, go to STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx < DATA_WIDTH/8-1: increment byte_idx, go to START (no extra gap).
    - Otherwise go to IDLE.
  - Bytes are sent least-significant byte first.
  - One word takes (DATA_WIDTH/8)*10*CLKS_PER_BIT cycles, plus one IDLE cycle before the next pop.
- busy = (FSM != IDLE).
- Latency: tx first drives 0 on the second rising edge after the edge that sampled the new a0 (edge 1: push; edge 2: pop + START).
- The baud counter is free of drift: it reloads exactly at each bit boundary and counts 0..CLKS_PER_BIT-1.
- The queued value is the a0 value at the push edge. Later a0 changes do not alter the word already queued.

Test Plan (all with CLKS_PER_BIT=4, DATA_WIDTH=32, FIFO_DEPTH=8):
- Reset: hold rst=0 with no clock toggling.
  - Required: tx=1, busy=0, overflow=0, fifo_count=0.
  - Release rst; with a0=0 stable, tx stays 1 for 200 cycles.
- Single word: en=1, a0 goes 0 → 0x12345678.
  - Required: tx start bit low 2 edges after the sampling edge.
  - Decoded bytes 0x78, 0x56, 0x34, 0x12, each framed 0 / 8 data bits / 1.
  - busy high for exactly 160 cycles, then fifo_count=0.
- Stable a0: hold a0=0xA5 for 1000 cycles after its first frame.
  - Required: exactly one frame emitted.
- Overflow: change a0 on 10 consecutive cycles to values 1..10.
  - Required: value 1 popped immediately; values 2..9 queued (fifo_count=8); value 10 dropped; overflow=1.
  - 9 words appear on tx in order 1..9.
  - Pulse clr_overflow → overflow=0.
- Enable gating: en=0, a0 goes to 0x55; then en=1 with a0 still 0x55.
  - Required: no push, fifo_count=0, tx idle.
  - Next change to 0x66 is sent.
- Async reset mid-frame: assert rst=0 during byte 2 of a word while 2 words are queued.
  - Required: tx=1 and busy=0 without waiting for a clock edge; fifo_count=0.
  - After release, no stale word is transmitted.
